// File: rtl/rf_scoreboard_pkg.sv
// Shared constants, types and helpers for the register-file write-pending scoreboard.
package rf_scoreboard_pkg;

  localparam int SB_NREG         = 32;  // architectural registers, r0 untracked
  localparam int SB_CW           = 2;   // counter width per register
  localparam int SB_MAX_INFLIGHT = 3;   // EX + MEM + WB writes to one register
  localparam int SB_AW           = 5;   // register address width
  localparam int SB_ERR_BIT      = 0;   // bit position of sb_err if folded into a status word

  typedef logic [SB_AW-1:0] reg_addr_t;

  // Operation applied to one in-flight counter in a cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_CLR  = 2'd3
  } cnt_op_e;

  // Clear dominates; a simultaneous inc and dec cancel out.
  function automatic cnt_op_e cnt_op(input logic clr, input logic inc, input logic dec);
    if (clr) return CNT_CLR;
    if (inc && !dec) return CNT_INC;
    if (dec && !inc) return CNT_DEC;
    return CNT_HOLD;
  endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// Decode/issue/writeback handshake bundle between the pipeline and the scoreboard.
interface rf_scoreboard_if;
  import rf_scoreboard_pkg::*;

  // ID stage source lookup
  logic      ds_valid;
  reg_addr_t ds_rs1;
  logic      ds_rs1_rd;
  reg_addr_t ds_rs2;
  logic      ds_rs2_rd;
  logic      ds_stall;
  // ID -> EX issue
  logic      iss_fire;
  logic      iss_we;
  reg_addr_t iss_dest;
  // WB retire
  logic      ret_fire;
  reg_addr_t ret_dest;
  // Pipeline redirect
  logic      flush;
  // Status
  logic      sb_busy;
  logic      sb_err;

  // Pipeline side
  modport master (
    output ds_valid, ds_rs1, ds_rs1_rd, ds_rs2, ds_rs2_rd,
    output iss_fire, iss_we, iss_dest, ret_fire, ret_dest, flush,
    input  ds_stall, sb_busy, sb_err
  );

  // Scoreboard side
  modport slave (
    input  ds_valid, ds_rs1, ds_rs1_rd, ds_rs2, ds_rs2_rd,
    input  iss_fire, iss_we, iss_dest, ret_fire, ret_dest, flush,
    output ds_stall, sb_busy, sb_err
  );

endinterface

// File: rtl/rf_scoreboard_sb_counter.sv
// One saturating up/down in-flight counter with synchronous clear and an
// error pulse on overflow (inc at MAX) or underflow (dec at zero).
module sb_counter
  import rf_scoreboard_pkg::*;
#(
  parameter int CW  = SB_CW,
  parameter int MAX = SB_MAX_INFLIGHT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] cnt_q,
  output logic [CW-1:0] cnt_d,
  output logic          err
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  // Next count: saturate at both ends and flag the offending event.
  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    unique case (cnt_op(clr, inc, dec))
      CNT_CLR: cnt_d = '0;
      CNT_INC: begin
        if (cnt_q == MAX_C) err = 1'b1;
        else                cnt_d = cnt_q + 1'b1;
      end
      CNT_DEC: begin
        if (cnt_q == '0) err = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Count register; async reset so a reset mid-stall releases ID at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Per-register write-pending scoreboard: single interlock source for the ID stage.
// Counts writes in flight per register, stalls ID on any pending source, and
// reports registered busy and sticky error status.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int NREG         = SB_NREG,          // must not exceed 2**SB_AW
  parameter int CW           = SB_CW,
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT   // must be <= 2**CW - 1
) (
  input  logic          clk,
  input  logic          resetn,
  rf_scoreboard_if.slave sb
);

  // Current counts, entry 0 tied to zero so r0 never interlocks.
  logic [CW-1:0]   cnt_q_arr [NREG];
  logic [CW-1:0]   cnt_d_arr [1:NREG-1];
  logic [NREG-1:1] inc_vec;
  logic [NREG-1:1] dec_vec;
  logic [NREG-1:1] err_vec;

  logic [CW-1:0] rs1_cnt;
  logic [CW-1:0] rs2_cnt;
  logic          busy_d, busy_q;
  logic          err_d,  err_q;

  assign cnt_q_arr[0] = '0;

  // Destination decode and one counter per tracked register.
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      assign inc_vec[gi] = sb.iss_fire && sb.iss_we && (sb.iss_dest == SB_AW'(gi));
      assign dec_vec[gi] = sb.ret_fire && (sb.ret_dest == SB_AW'(gi));

      sb_counter #(
        .CW  (CW),
        .MAX (MAX_INFLIGHT)
      ) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (inc_vec[gi]),
        .dec    (dec_vec[gi]),
        .clr    (sb.flush),
        .cnt_q  (cnt_q_arr[gi]),
        .cnt_d  (cnt_d_arr[gi]),
        .err    (err_vec[gi])
      );
    end
  endgenerate

  // Source-read mux from registered counts only: regfile reads are not
  // write-through, so a same-cycle retire must not release the stall.
  always_comb begin
    rs1_cnt = cnt_q_arr[sb.ds_rs1];
    rs2_cnt = cnt_q_arr[sb.ds_rs2];
  end

  assign sb.ds_stall = sb.ds_valid &&
                       ((sb.ds_rs1_rd && (rs1_cnt != '0)) ||
                        (sb.ds_rs2_rd && (rs2_cnt != '0)));

  // Busy tracks next-state counts so it lines up with the registered counts;
  // error is sticky and survives flush.
  always_comb begin
    busy_d = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      busy_d = busy_d | (cnt_d_arr[i] != '0);
    end
    err_d = err_q | (|err_vec);
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign sb.sb_busy = busy_q;
  assign sb.sb_err  = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: vector table with a post-edge
// expectation queue, plus hand sequences for async reset and underflow.
module tb_rf_scoreboard;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  rf_scoreboard_if sb_if ();

  rf_scoreboard #(
    .NREG         (32),
    .CW           (2),
    .MAX_INFLIGHT (3)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sb_if)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus expectations: stall is checked before the
  // edge, probe/cnt/busy/err after it.
  typedef struct {
    int v; int rs1; int r1rd; int rs2; int r2rd;
    int ifire; int iwe; int idest; int rfire; int rdest; int fl;
    int stall; int probe; int cnt; int busy; int err;
  } vec_t;

  typedef struct {
    int id; int probe; int cnt; int busy; int err;
  } exp_t;

  vec_t tbl [27];
  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic drive(input vec_t t);
    sb_if.ds_valid  = (t.v != 0);
    sb_if.ds_rs1    = 5'(t.rs1);
    sb_if.ds_rs1_rd = (t.r1rd != 0);
    sb_if.ds_rs2    = 5'(t.rs2);
    sb_if.ds_rs2_rd = (t.r2rd != 0);
    sb_if.iss_fire  = (t.ifire != 0);
    sb_if.iss_we    = (t.iwe != 0);
    sb_if.iss_dest  = 5'(t.idest);
    sb_if.ret_fire  = (t.rfire != 0);
    sb_if.ret_dest  = 5'(t.rdest);
    sb_if.flush     = (t.fl != 0);
  endtask

  // Pop the oldest expectation and compare against registered state.
  task automatic pop_and_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("v%0d_cnt_r%0d", e.id, e.probe), int'(u_dut.cnt_q_arr[e.probe]), e.cnt);
    check($sformatf("v%0d_busy", e.id), int'(sb_if.sb_busy), e.busy);
    check($sformatf("v%0d_err", e.id), int'(sb_if.sb_err), e.err);
    $display("vec %0d: stall=%0d cnt[r%0d]=%0d busy=%0d err=%0d", e.id, sb_if.ds_stall,
             e.probe, u_dut.cnt_q_arr[e.probe], sb_if.sb_busy, sb_if.sb_err);
  endtask

  vec_t idle;

  initial begin
    //           v rs1 r1 rs2 r2 if we dst rf rdst fl | st prb cnt bsy err
    // RAW chain on r5
    tbl[0]  = '{1, 5, 1, 0, 0,  0, 0, 0,  0, 0,  0,   0, 5, 0, 0, 0};
    tbl[1]  = '{1, 5, 1, 0, 0,  1, 1, 5,  0, 0,  0,   0, 5, 1, 1, 0};
    tbl[2]  = '{1, 5, 1, 0, 0,  0, 0, 0,  0, 0,  0,   1, 5, 1, 1, 0};
    tbl[3]  = '{1, 5, 1, 0, 0,  0, 0, 0,  0, 0,  0,   1, 5, 1, 1, 0};
    tbl[4]  = '{1, 5, 1, 0, 0,  0, 0, 0,  1, 5,  0,   1, 5, 0, 0, 0};
    tbl[5]  = '{1, 5, 1, 0, 0,  0, 0, 0,  0, 0,  0,   0, 5, 0, 0, 0};
    // Multiple in flight on r7, then overflow
    tbl[6]  = '{1, 7, 1, 0, 0,  1, 1, 7,  0, 0,  0,   0, 7, 1, 1, 0};
    tbl[7]  = '{1, 7, 1, 0, 0,  1, 1, 7,  0, 0,  0,   1, 7, 2, 1, 0};
    tbl[8]  = '{1, 7, 1, 0, 0,  1, 1, 7,  0, 0,  0,   1, 7, 3, 1, 0};
    tbl[9]  = '{1, 7, 1, 0, 0,  0, 0, 0,  1, 7,  0,   1, 7, 2, 1, 0};
    tbl[10] = '{1, 7, 1, 0, 0,  1, 1, 7,  0, 0,  0,   1, 7, 3, 1, 0};
    tbl[11] = '{1, 7, 1, 0, 0,  1, 1, 7,  0, 0,  0,   1, 7, 3, 1, 1};
    // Drain r7 while reading r0 on both ports
    tbl[12] = '{1, 0, 1, 0, 1,  0, 0, 0,  1, 7,  0,   0, 7, 2, 1, 1};
    tbl[13] = '{1, 0, 1, 0, 1,  0, 0, 0,  1, 7,  0,   0, 7, 1, 1, 1};
    tbl[14] = '{1, 0, 1, 0, 1,  0, 0, 0,  1, 7,  0,   0, 7, 0, 0, 1};
    // Simultaneous inc/dec, unused sources, ds_valid=0
    tbl[15] = '{1, 7, 1, 0, 0,  1, 1, 9,  0, 0,  0,   0, 9, 1, 1, 1};
    tbl[16] = '{0, 9, 1, 0, 0,  1, 1, 9,  1, 9,  0,   0, 9, 1, 1, 1};
    tbl[17] = '{1, 9, 0, 9, 0,  1, 1, 3,  0, 0,  0,   0, 3, 1, 1, 1};
    tbl[18] = '{1, 0, 0, 9, 1,  1, 1, 4,  0, 0,  0,   1, 4, 1, 1, 1};
    tbl[19] = '{1, 3, 1, 0, 0,  1, 1, 3,  1, 4,  0,   1, 4, 0, 1, 1};
    tbl[20] = '{1, 4, 1, 0, 0,  0, 0, 0,  0, 0,  0,   0, 3, 2, 1, 1};
    // r0 destination is never tracked
    tbl[21] = '{1, 0, 1, 0, 0,  1, 1, 0,  0, 0,  0,   0, 0, 0, 1, 1};
    tbl[22] = '{1, 0, 1, 0, 1,  0, 0, 0,  0, 0,  0,   0, 0, 0, 1, 1};
    // r2 and r8 pending, then flush with coincident retire r2 and issue r9
    tbl[23] = '{1, 2, 1, 0, 0,  1, 1, 2,  0, 0,  0,   0, 2, 1, 1, 1};
    tbl[24] = '{1, 2, 1, 0, 0,  1, 1, 8,  0, 0,  0,   1, 8, 1, 1, 1};
    tbl[25] = '{1, 8, 1, 0, 0,  1, 1, 9,  1, 2,  1,   1, 2, 0, 0, 1};
    tbl[26] = '{1, 2, 1, 8, 1,  0, 0, 0,  0, 0,  0,   0, 8, 0, 0, 1};

    idle = '{0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0,   0, 0, 0, 0, 0};

    // Reset with ID presenting a read of r5
    drive(idle);
    sb_if.ds_valid  = 1'b1;
    sb_if.ds_rs1    = 5'd5;
    sb_if.ds_rs1_rd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", int'(sb_if.ds_stall), 0);
    check("reset_busy", int'(sb_if.sb_busy), 0);
    check("reset_err", int'(sb_if.sb_err), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 27; i++) begin
      exp_t e;
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("v%0d_stall", i), int'(sb_if.ds_stall), tbl[i].stall);
      e = '{i, tbl[i].probe, tbl[i].cnt, tbl[i].busy, tbl[i].err};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      pop_and_check();
    end

    // Async reset mid-stall: issue r6, dependent stalls, reset drops it at once
    @(negedge clk);
    drive(idle);
    sb_if.ds_valid  = 1'b1;
    sb_if.ds_rs1    = 5'd6;
    sb_if.ds_rs1_rd = 1'b1;
    sb_if.iss_fire  = 1'b1;
    sb_if.iss_we    = 1'b1;
    sb_if.iss_dest  = 5'd6;
    @(posedge clk);
    #1;
    sb_if.iss_fire = 1'b0;
    sb_if.iss_we   = 1'b0;
    #1;
    check("areset_pre_stall", int'(sb_if.ds_stall), 1);
    check("areset_pre_busy", int'(sb_if.sb_busy), 1);
    resetn = 1'b0;
    #1;
    check("areset_stall", int'(sb_if.ds_stall), 0);
    check("areset_busy", int'(sb_if.sb_busy), 0);
    check("areset_err", int'(sb_if.sb_err), 0);
    check("areset_cnt_r6", int'(u_dut.cnt_q_arr[6]), 0);
    $display("areset: stall=%0d busy=%0d err=%0d", sb_if.ds_stall, sb_if.sb_busy, sb_if.sb_err);
    @(negedge clk);
    resetn = 1'b1;

    // Underflow: retire r10 with nothing in flight
    @(negedge clk);
    drive(idle);
    sb_if.ret_fire = 1'b1;
    sb_if.ret_dest = 5'd10;
    exp_q.push_back('{100, 10, 0, 0, 1});
    @(posedge clk);
    #1;
    pop_and_check();

    // Error stays sticky after traffic resumes normally
    @(negedge clk);
    drive(idle);
    sb_if.iss_fire = 1'b1;
    sb_if.iss_we   = 1'b1;
    sb_if.iss_dest = 5'd11;
    exp_q.push_back('{101, 11, 1, 1, 1});
    @(posedge clk);
    #1;
    pop_and_check();

    @(negedge clk);
    drive(idle);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
